// File: rtl/dual_input_debouncer_if.sv
// ---------------------------------------------------------------------------
// dual_input_debouncer_if
// Bundles the two raw switch inputs of the dual debouncer with its clean
// levels and edge pulses.
//   a_in, b_in       raw asynchronous channel inputs (driven by master)
//   a, b             debounced levels, feeding the downstream OR stage
//   a_rise, a_fall   one-cycle pulses on 0->1 / 1->0 changes of a
//   b_rise, b_fall   one-cycle pulses on 0->1 / 1->0 changes of b
// master: the side that owns the raw pins and consumes the clean outputs.
// slave : the debouncer itself.
// ---------------------------------------------------------------------------
interface dual_input_debouncer_if;
   logic a_in;
   logic b_in;
   logic a;
   logic b;
   logic a_rise;
   logic a_fall;
   logic b_rise;
   logic b_fall;

   modport master (
      output a_in, b_in,
      input  a, b, a_rise, a_fall, b_rise, b_fall
   );

   modport slave (
      input  a_in, b_in,
      output a, b, a_rise, a_fall, b_rise, b_fall
   );
endinterface

// File: rtl/dual_input_debouncer.sv
// ---------------------------------------------------------------------------
// dual_input_debouncer
// Two independent switch debouncers. Each raw input is brought into the clk
// domain by a 2-flop synchronizer; the clean level only follows the
// synchronized value once it has differed from the current level for
// STABLE_CYCLES consecutive edges. A registered rise/fall pulse marks the
// cycle in which the clean level first shows its new value.
//   clk   sole clock, rising edge
//   rst   synchronous, active-high reset; clears every flop
//   bus   dual_input_debouncer_if.slave (a_in/b_in in; a, b and pulses out)
// Parameter STABLE_CYCLES: 1..255, default 4.
// Latency for a held raw change is STABLE_CYCLES+2 edges (2 synchronizer
// edges, then STABLE_CYCLES edges of disagreement).
// ---------------------------------------------------------------------------
module dual_input_debouncer #(
   parameter int STABLE_CYCLES = 4
) (
   input logic                   clk,
   input logic                   rst,
   dual_input_debouncer_if.slave bus
);

   localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   // Channel index 0 is A, 1 is B.
   logic [1:0]       raw;
   logic [1:0]       sync1;
   logic [1:0]       sync2;
   logic [1:0]       level;
   logic [1:0]       rise;
   logic [1:0]       fall;
   logic [CNT_W-1:0] cnt [2];

   assign raw = {bus.b_in, bus.a_in};

   always_ff @(posedge clk) begin
      for (int ch = 0; ch < 2; ch++) begin
         if (rst) begin
            sync1[ch] <= 1'b0;
            sync2[ch] <= 1'b0;
            level[ch] <= 1'b0;
            rise[ch]  <= 1'b0;
            fall[ch]  <= 1'b0;
            cnt[ch]   <= '0;
         end else begin
            // Synchronizer stage boundary: raw -> sync1 -> sync2.
            sync1[ch] <= raw[ch];
            sync2[ch] <= sync1[ch];

            // Pulses default low; they are set only on the edge the level flips.
            rise[ch] <= 1'b0;
            fall[ch] <= 1'b0;

            if (sync2[ch] == level[ch]) begin
               // Any agreement restarts the stability window, which is what
               // rejects glitches shorter than STABLE_CYCLES.
               cnt[ch] <= '0;
            end else if (cnt[ch] == CNT_LAST) begin
               // Last disagreeing edge of the window: commit the new level.
               // The counter never passes CNT_LAST, so no wrap is possible.
               level[ch] <= sync2[ch];
               rise[ch]  <= sync2[ch];
               fall[ch]  <= ~sync2[ch];
               cnt[ch]   <= '0;
            end else begin
               cnt[ch] <= cnt[ch] + CNT_W'(1);
            end
         end
      end
   end

   // Outputs come straight from flops; no combinational path from the pins.
   assign bus.a      = level[0];
   assign bus.b      = level[1];
   assign bus.a_rise = rise[0];
   assign bus.a_fall = fall[0];
   assign bus.b_rise = rise[1];
   assign bus.b_fall = fall[1];

endmodule

// File: tb/tb_dual_input_debouncer.sv
// ---------------------------------------------------------------------------
// tb_dual_input_debouncer
// Directed bench for dual_input_debouncer at STABLE_CYCLES = 4.
// Inputs are changed 1 time unit after a rising edge, so the next rising edge
// is sampling edge 1 of that change; outputs are observed at the same point.
// Observed vector: {a, b, a_rise, a_fall, b_rise, b_fall}.
// ---------------------------------------------------------------------------
module tb_dual_input_debouncer;

   logic clk;
   logic rst;
   int   checks;
   int   fails;

   dual_input_debouncer_if bus ();

   dual_input_debouncer #(.STABLE_CYCLES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [5:0] obs;
   assign obs = {bus.a, bus.b, bus.a_rise, bus.a_fall, bus.b_rise, bus.b_fall};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset clears everything; idle inputs then produce nothing.
   task automatic test_reset();
      logic [5:0] exp;
      rst = 1'b1;
      bus.a_in = 1'b0;
      bus.b_in = 1'b0;
      tick();
      tick();
      exp = 6'b000000;
      checks++;
      if (obs !== exp) begin
         $display("FAIL reset_state: got %b expected %b", obs, exp);
         fails++;
      end
      rst = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         checks++;
         if (obs !== exp) begin
            $display("FAIL idle edge %0d: got %b expected %b", i, obs, exp);
            fails++;
         end
      end
   endtask

   // a rises on the 6th sampling edge, falls on the 6th after release.
   task automatic test_a_rise_fall();
      logic [5:0] exp;
      bus.a_in = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         exp = {(i >= 6), 1'b0, (i == 6), 1'b0, 1'b0, 1'b0};
         checks++;
         if (obs !== exp) begin
            $display("FAIL a_rise edge %0d: got %b expected %b", i, obs, exp);
            fails++;
         end
      end
      bus.a_in = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         exp = {(i < 6), 1'b0, 1'b0, (i == 6), 1'b0, 1'b0};
         checks++;
         if (obs !== exp) begin
            $display("FAIL a_fall edge %0d: got %b expected %b", i, obs, exp);
            fails++;
         end
      end
   endtask

   // 3-cycle b glitch is rejected; a following held 1 still needs the full
   // 6 edges, which shows the counter went back to 0.
   task automatic test_glitch_b();
      logic [5:0] exp;
      bus.b_in = 1'b1;
      for (int i = 1; i <= 13; i++) begin
         tick();
         if (i == 3) bus.b_in = 1'b0;
         exp = 6'b000000;
         checks++;
         if (obs !== exp) begin
            $display("FAIL b_glitch edge %0d: got %b expected %b", i, obs, exp);
            fails++;
         end
      end
      bus.b_in = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick();
         exp = {1'b0, (i >= 6), 1'b0, 1'b0, (i == 6), 1'b0};
         checks++;
         if (obs !== exp) begin
            $display("FAIL b_after_glitch edge %0d: got %b expected %b", i, obs, exp);
            fails++;
         end
      end
      bus.b_in = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         tick();
         exp = {1'b0, (i < 6), 1'b0, 1'b0, 1'b0, (i == 6)};
         checks++;
         if (obs !== exp) begin
            $display("FAIL b_clear edge %0d: got %b expected %b", i, obs, exp);
            fails++;
         end
      end
   endtask

   // Both channels change together and flip on the same edges.
   task automatic test_simultaneous();
      logic [5:0] exp;
      bus.a_in = 1'b1;
      bus.b_in = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         exp = {(i >= 6), (i >= 6), (i == 6), 1'b0, (i == 6), 1'b0};
         checks++;
         if (obs !== exp) begin
            $display("FAIL both_rise edge %0d: got %b expected %b", i, obs, exp);
            fails++;
         end
      end
      bus.a_in = 1'b0;
      bus.b_in = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         exp = {(i < 6), (i < 6), 1'b0, (i == 6), 1'b0, (i == 6)};
         checks++;
         if (obs !== exp) begin
            $display("FAIL both_fall edge %0d: got %b expected %b", i, obs, exp);
            fails++;
         end
      end
   endtask

   // Reset on the 4th sampling edge discards the partial count; then reset
   // while a=1 must clear a without an a_fall pulse.
   task automatic test_reset_mid();
      logic [5:0] exp;
      bus.a_in = 1'b1;
      exp = 6'b000000;
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++;
         if (obs !== exp) begin
            $display("FAIL pre_reset edge %0d: got %b expected %b", i, obs, exp);
            fails++;
         end
      end
      rst = 1'b1;
      for (int i = 1; i <= 2; i++) begin
         tick();
         checks++;
         if (obs !== exp) begin
            $display("FAIL in_reset edge %0d: got %b expected %b", i, obs, exp);
            fails++;
         end
      end
      rst = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         tick();
         exp = {(i >= 6), 1'b0, (i == 6), 1'b0, 1'b0, 1'b0};
         checks++;
         if (obs !== exp) begin
            $display("FAIL post_reset edge %0d: got %b expected %b", i, obs, exp);
            fails++;
         end
      end
      rst = 1'b1;
      tick();
      exp = 6'b000000;
      checks++;
      if (obs !== exp) begin
         $display("FAIL reset_entry: got %b expected %b", obs, exp);
         fails++;
      end
      rst = 1'b0;
      bus.a_in = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         checks++;
         if (obs !== exp) begin
            $display("FAIL reset_exit edge %0d: got %b expected %b", i, obs, exp);
            fails++;
         end
      end
   endtask

   // Bounce 1,0,1,1,0,1 then held 1: the synchronized value is first stable
   // from edge 8, so a rises on edge 11 with a single a_rise.
   task automatic test_bounce();
      logic [5:0] exp;
      logic [5:0] pattern;
      pattern = 6'b101101;
      for (int i = 1; i <= 14; i++) begin
         bus.a_in = (i <= 6) ? pattern[6 - i] : 1'b1;
         tick();
         exp = {(i >= 11), 1'b0, (i == 11), 1'b0, 1'b0, 1'b0};
         checks++;
         if (obs !== exp) begin
            $display("FAIL bounce edge %0d: got %b expected %b", i, obs, exp);
            fails++;
         end
      end
      bus.a_in = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         tick();
         exp = {(i < 6), 1'b0, 1'b0, (i == 6), 1'b0, 1'b0};
         checks++;
         if (obs !== exp) begin
            $display("FAIL bounce_clear edge %0d: got %b expected %b", i, obs, exp);
            fails++;
         end
      end
   endtask

   initial begin
      checks   = 0;
      fails    = 0;
      rst      = 1'b1;
      bus.a_in = 1'b0;
      bus.b_in = 1'b0;
      test_reset();
      test_a_rise_fall();
      test_glitch_b();
      test_simultaneous();
      test_reset_mid();
      test_bounce();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/dual_input_debouncer.md
DUAL_INPUT_DEBOUNCER -- requirements
Module: dual_input_debouncer

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, number of consecutive cycles a synchronized input must differ from its output before the output changes; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 a_in  input  1  raw asynchronous channel A (switch/pin).
REQ-005 b_in  input  1  raw asynchronous channel B.
REQ-006 a  output  1  clean, debounced level of channel A; feeds operand a of the downstream 2-input OR stage.
REQ-007 b  output  1  clean, debounced level of channel B; feeds operand b of the downstream OR stage.
REQ-008 a_rise, a_fall, b_rise, b_fall  output  1 each  single-cycle pulses marking a 0->1 or 1->0 change of a or b.

Function
REQ-009 Each channel SHALL be processed by an identical, independent instance of the logic in REQ-010..REQ-016; there is no interaction between channels.
REQ-010 Each raw input SHALL pass through a 2-flop synchronizer (sync1, sync2); only sync2 is used downstream.
REQ-011 Each channel SHALL own a stability counter of width clog2(STABLE_CYCLES+1) bits.
REQ-012 On an edge where sync2 equals the channel output, the counter SHALL clear to 0.
REQ-013 On an edge where sync2 differs from the output and counter < STABLE_CYCLES-1, the counter SHALL increment by 1.
REQ-014 On an edge where sync2 differs from the output and counter == STABLE_CYCLES-1, the output SHALL take the value of sync2 and the counter SHALL clear to 0.
REQ-015 The rise (fall) pulse SHALL be registered, high for exactly the one cycle in which the output first shows 1 (0), and low at all other times.
REQ-016 Latency: for a raw level held steady, the output SHALL change on the (STABLE_CYCLES+2)th rising edge sampling the new raw value, counting the first such edge as 1 (6 edges at default).
REQ-017 Glitch rejection: a raw change that reverts before REQ-016 completes SHALL leave the output and pulses unchanged, and the counter SHALL return to 0.
REQ-018 Counter SHALL never exceed STABLE_CYCLES-1; no wrap-around is possible.
REQ-019 Simultaneous changes on a_in and b_in SHALL be debounced independently, and both outputs may change on the same edge.
REQ-020 Outputs a and b SHALL be driven directly from flops, with no combinational path from a_in/b_in.

Reset
REQ-021 While rst is high at a rising edge, sync1, sync2, counters, a, b and all four pulses SHALL be 0 after that edge.
REQ-022 Reset asserted mid-debounce SHALL discard the partial count; after release, a raw input held at 1 SHALL produce a rising output per REQ-016, counted from the first post-reset sampling edge.
REQ-023 No pulse SHALL be generated by entry into or exit from reset.

Verification (STABLE_CYCLES=4)
REQ-024 Reset, a_in=b_in=0 for 10 cycles -> a=b=0; no pulses.
REQ-025 a_in 0->1 held -> a rises on the 6th sampling edge; a_rise high for that one cycle only; b, b pulses stay 0.
REQ-026 b_in pulsed high for 3 cycles, then 0 -> b stays 0; no b_rise; counter back to 0.
REQ-027 a_in=b_in=1 applied together, then both dropped to 0 after 20 cycles -> a and b rise on the same edge and fall on the same edge; all four pulses seen exactly once.
REQ-028 a_in held 1, rst asserted on the 4th sampling edge for 2 cycles -> a remains 0 and a_rise is not pulsed during reset; a rises 6 edges after the first post-reset sampling edge.
REQ-029 Bounce pattern on a_in (1,0,1,1,0,1, then 1 held) -> a rises only after 4 consecutive stable synchronized cycles; exactly one a_rise pulse.
